// File: rtl/shift_tx_ctrl_piso_shift_reg.sv
// Parallel-load, right-shift register feeding the serial output.
// Load wins over shift so a restart or clear is never lost to a shift.
module piso_shift_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         q0
);
  logic [N-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {1'b0, q[N-1:1]};
  end

  assign q0 = q[0];
endmodule

// File: rtl/shift_tx_ctrl.sv
// Parallel-in/serial-out transmitter controller: LSB first, DIV clocks per bit,
// busy while sending, bit_tick per bit period, done_tick on the final bit cycle.
module shift_tx_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] din,
  output logic         sh_out,
  output logic         busy,
  output logic         done_tick,
  output logic         bit_tick
);
  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(N);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  logic          state;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          accept;
  logic          q0;

  assign accept    = (state == IDLE) && start;
  assign busy      = (state == SHIFT);
  assign bit_tick  = busy && (div_cnt == DIV_LAST);
  assign done_tick = bit_tick && (bit_cnt == BIT_LAST);
  assign sh_out    = busy & q0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        default: begin
          div_cnt <= bit_tick ? '0 : div_cnt + DW'(1);
          if (bit_tick) begin
            if (bit_cnt == BIT_LAST) state <= IDLE;
            else                     bit_cnt <= bit_cnt + BW'(1);
          end
        end
      endcase
    end
  end

  // Reloading with zero on the final tick leaves the shifter clean for IDLE.
  piso_shift_reg #(.N(N)) u_sreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept | done_tick),
    .shift (bit_tick & ~done_tick),
    .din   (accept ? din : '0),
    .q0    (q0)
  );
endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Scoreboard bench: per-cycle expected {sh_out,busy,bit_tick,done_tick} queued at start.
module tb_shift_tx_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start1 = 1'b0;
  logic [7:0] din = '0, din1 = '0;
  logic       sh_out, busy, done_tick, bit_tick;
  logic       sh_out1, busy1, done_tick1, bit_tick1;
  logic [3:0] sbq[$];
  logic [3:0] exp_v, obs;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  shift_tx_ctrl #(.N(8), .DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .sh_out(sh_out), .busy(busy), .done_tick(done_tick), .bit_tick(bit_tick));

  shift_tx_ctrl #(.N(8), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1),
    .sh_out(sh_out1), .busy(busy1), .done_tick(done_tick1), .bit_tick(bit_tick1));

  function automatic void push_word(input logic [7:0] w, input int d);
    for (int c = 0; c < 8 * d; c++) begin
      int b, p;
      b = c / d;
      p = c % d;
      sbq.push_back({w[b], 1'b1, p == d - 1, (p == d - 1) && (b == 7)});
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    obs = {sh_out, busy, bit_tick, done_tick, sh_out1, busy1, bit_tick1, done_tick1} == 8'h00 ? 4'h0 : 4'hF;
    checks++;
    if (obs !== 4'h0) begin
      failures++;
      $display("FAIL reset_outputs obs=%b%b%b%b/%b%b%b%b exp=0", sh_out, busy, bit_tick, done_tick,
               sh_out1, busy1, bit_tick1, done_tick1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_a5();
    int i = 0;
    din = 8'hA5; start = 1'b1;
    push_word(8'hA5, 4);
    while (sbq.size() > 0) begin
      @(negedge clk);
      exp_v = sbq.pop_front();
      obs = {sh_out, busy, bit_tick, done_tick};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL a5_cycle%0d obs=%b exp=%b", i + 1, obs, exp_v);
      end
      start = 1'b0;
      i++;
    end
    @(negedge clk);
    checks++;
    if ({sh_out, busy} !== 2'b00) begin
      failures++;
      $display("FAIL a5_after_idle obs=%b exp=00", {sh_out, busy});
    end
  endtask

  task automatic test_start_while_busy();
    int i = 0, dones = 0;
    din = 8'h3C; start = 1'b1;
    push_word(8'h3C, 4);
    while (sbq.size() > 0) begin
      @(negedge clk);
      exp_v = sbq.pop_front();
      obs = {sh_out, busy, bit_tick, done_tick};
      dones += done_tick;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL busy_start_cycle%0d obs=%b exp=%b", i + 1, obs, exp_v);
      end
      start = (i == 9) || (i == 31);
      i++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      dones += done_tick;
      checks++;
      if ({sh_out, busy} !== 2'b00) begin
        failures++;
        $display("FAIL busy_start_ignored k=%0d obs=%b exp=00", k, {sh_out, busy});
      end
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL busy_start_done_count obs=%0d exp=1", dones);
    end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    din = 8'hFF; start = 1'b1;
    push_word(8'hFF, 4);
    sbq.push_back(4'b0000);
    push_word(8'h01, 4);
    while (sbq.size() > 0) begin
      @(negedge clk);
      exp_v = sbq.pop_front();
      obs = {sh_out, busy, bit_tick, done_tick};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL b2b_cycle%0d obs=%b exp=%b", i + 1, obs, exp_v);
      end
      if (i == 0) din = 8'h01;
      if (i == 33) start = 1'b0;
      i++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int i = 0, dones = 0;
    din = 8'h5A; start = 1'b1;
    push_word(8'h5A, 4);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      exp_v = sbq.pop_front();
      obs = {sh_out, busy, bit_tick, done_tick};
      dones += done_tick;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL abort_pre_cycle%0d obs=%b exp=%b", k + 1, obs, exp_v);
      end
      start = 1'b0;
    end
    sbq.delete();
    #2 rst = 1'b1;
    #1;
    obs = {sh_out, busy, bit_tick, done_tick};
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL abort_async_drop obs=%b exp=0000", obs);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, dones} !== {1'b0, 32'd0}) begin
      failures++;
      $display("FAIL abort_idle_no_done busy=%b dones=%0d exp=0/0", busy, dones);
    end
    din = 8'h5A; start = 1'b1;
    push_word(8'h5A, 4);
    while (sbq.size() > 0) begin
      @(negedge clk);
      exp_v = sbq.pop_front();
      obs = {sh_out, busy, bit_tick, done_tick};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL abort_restart_cycle%0d obs=%b exp=%b", i + 1, obs, exp_v);
      end
      start = 1'b0;
      i++;
    end
    @(negedge clk);
  endtask

  task automatic test_div1();
    int i = 0;
    din1 = 8'hC3; start1 = 1'b1;
    push_word(8'hC3, 1);
    sbq.push_back(4'b0000);
    while (sbq.size() > 0) begin
      @(negedge clk);
      exp_v = sbq.pop_front();
      obs = {sh_out1, busy1, bit_tick1, done_tick1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL div1_cycle%0d obs=%b exp=%b", i + 1, obs, exp_v);
      end
      start1 = 1'b0;
      i++;
    end
  endtask

  task automatic test_din_change();
    int i = 0;
    din = 8'h0F; start = 1'b1;
    push_word(8'h0F, 4);
    while (sbq.size() > 0) begin
      @(negedge clk);
      exp_v = sbq.pop_front();
      obs = {sh_out, busy, bit_tick, done_tick};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL din_change_cycle%0d obs=%b exp=%b", i + 1, obs, exp_v);
      end
      start = 1'b0;
      din = 8'hF0;
      i++;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    test_div1();
    test_din_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_tx_ctrl.md
Name: shift_tx_ctrl

Overview:
Controller that sequences a right-shifting serial datapath as a parallel-in, serial-out transmitter. On a start request it captures an N-bit word and shifts it out LSB first, holding each bit for DIV clock cycles. It reports busy and pulses done when the last bit period ends. It sits between a parallel data source (register file or FSM) and a single-wire serial output.

Parameters:
N, 8, word width in bits (>=2)
DIV, 4, clock cycles per transmitted bit (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  transmit request, sampled only in IDLE
din  input  N  parallel word, captured in the cycle start is accepted
sh_out  output  1  serial data, LSB of internal shifter
busy  output  1  high while a word is being transmitted
done_tick  output  1  one-cycle pulse in the final cycle of the last bit
bit_tick  output  1  one-cycle pulse in the final cycle of every bit period

Behaviour:
- Reset (async, rst=1): state=IDLE, shifter=0, div_cnt=0, bit_cnt=0. While reset is held, sh_out=0, busy=0, done_tick=0, bit_tick=0.
- States: IDLE, SHIFT. No other states.
- IDLE:
  - busy=0 and sh_out=0.
  - If start=1 at a rising edge: shifter<=din, div_cnt<=0, bit_cnt<=0, state<=SHIFT.
  - Otherwise hold.
- SHIFT:
  - busy=1 and sh_out=shifter[0].
  - div_cnt increments each cycle. When div_cnt==DIV-1, bit_tick=1 and div_cnt wraps to 0.
  - On bit_tick with bit_cnt<N-1: shifter<={1'b0, shifter[N-1:1]} and bit_cnt increments.
  - On bit_tick with bit_cnt==N-1: done_tick=1, state<=IDLE, shifter<=0.
- Latency:
  - The first bit appears on sh_out in the cycle after start is accepted.
  - busy stays high for exactly N*DIV cycles.
  - done_tick coincides with the last busy cycle.
- Outputs bit_tick and done_tick are combinational from state and counters. They are glitch-free at clock edges and are registered by consumers.
- Simultaneous events:
  - start while busy (including the done_tick cycle) is ignored and not queued.
  - din changes during SHIFT have no effect.
- Back-to-back: a start held high continuously gives one idle cycle (busy=0) between words.
- Reset mid-transmission aborts immediately. No done_tick is produced, and after release the block is in IDLE.
- DIV=1: bit_tick is high every SHIFT cycle and div_cnt is constant 0. Its width is clamped to 1 bit.
- Widths:
  - div_cnt is $clog2(DIV) bits, minimum 1.
  - bit_cnt is $clog2(N) bits.
  - All comparisons use width-matched constants, so there is no overflow at the terminal counts.

Decomposition:
- No package is needed. State encodings (IDLE=1'b0, SHIFT=1'b1) are localparams in the module.
- One sub-module is natural: piso_shift_reg, a parallel-load right-shift register with inputs load, shift, din[N-1:0] and output q0. load has priority over shift.
- The FSM and both counters stay in shift_tx_ctrl.

Test Plan:
1. N=8, DIV=4, din=8'hA5, one-cycle start -> sh_out=1,0,1,0,0,1,0,1, each bit for 4 cycles. busy high for 32 cycles. done_tick high only in cycle 32. 8 bit_tick pulses, 4 cycles apart.
2. Start pulsed again at cycles 10 and 32 of a transmission of 8'h3C -> both ignored. Exactly one word is sent, with one done_tick.
3. start held high, din=8'hFF then 8'h01 -> two words sent, separated by exactly one cycle with busy=0 and sh_out=0. Second word is 1,0,0,0,0,0,0,0.
4. rst asserted asynchronously mid-cycle during bit 3 of 8'h5A -> sh_out, busy and ticks drop to 0 without waiting for a clock edge. No done_tick. A new start after release sends a full word.
5. N=8, DIV=1, din=8'hC3 -> sh_out=1,1,0,0,0,0,1,1 on consecutive cycles. busy high for 8 cycles. bit_tick high for all 8 cycles.
6. din changed from 8'h0F to 8'hF0 one cycle after start -> the transmitted bits are still 8'h0F (1,1,1,1,0,0,0,0).
